// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the ALU issue unit.
// Holds the ALU function codes, the RV32I opcodes the decoder recognises,
// and the issue FSM state type.
package alu_issue_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] FUN_ADD    = 4'b0000;
    localparam logic [3:0] FUN_SUB    = 4'b1000;
    localparam logic [3:0] FUN_OR     = 4'b0110;
    localparam logic [3:0] FUN_AND    = 4'b0111;
    localparam logic [3:0] FUN_XOR    = 4'b0100;
    localparam logic [3:0] FUN_SRL    = 4'b0101;
    localparam logic [3:0] FUN_SLL    = 4'b0001;
    localparam logic [3:0] FUN_SRA    = 4'b1101;
    localparam logic [3:0] FUN_SLT    = 4'b0010;
    localparam logic [3:0] FUN_SLTU   = 4'b0011;
    localparam logic [3:0] FUN_PASS_A = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the issue handshake, the ALU operand/result wires
// and the writeback handshake. The unit uses the slave view; whatever sits
// around it (register read, ALU, writeback) uses the master view.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_fun;
    logic [XLEN-1:0] alu_out;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            illegal;

    modport slave (
        input  in_valid, ir, pc, rs1, rs2, alu_out, out_ready,
        output in_ready, alu_a, alu_b, alu_fun, out_valid, result, rd, illegal
    );

    modport master (
        output in_valid, ir, pc, rs1, rs2, alu_out, out_ready,
        input  in_ready, alu_a, alu_b, alu_fun, out_valid, result, rd, illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational RV32I integer decode.
// Turns an instruction plus its operands into ALU operand A, operand B and
// the 4-bit function code, and flags anything it cannot issue.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [XLEN-1:0] ir,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      fun,
    output logic            illegal
);

    // The rs1 index field is resolved upstream; only its value arrives here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^ir[19:15];

    // Opcode decode; unrecognised encodings fall through to zero operands and ADD.
    always_comb begin
        a       = '0;
        b       = '0;
        fun     = FUN_ADD;
        illegal = 1'b0;
        case (ir[6:0])
            OPC_OP: begin
                if (ir[31:25] == 7'b0000000 || ir[31:25] == 7'b0100000) begin
                    a   = rs1;
                    b   = rs2;
                    fun = {ir[30], ir[14:12]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a   = rs1;
                b   = {{20{ir[31]}}, ir[31:20]};
                fun = {(ir[14:12] == 3'b101) ? ir[30] : 1'b0, ir[14:12]};
            end
            OPC_LUI: begin
                a   = {ir[31:12], 12'b0};
                fun = FUN_PASS_A;
            end
            OPC_AUIPC: begin
                a   = pc;
                b   = {ir[31:12], 12'b0};
                fun = FUN_ADD;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue-side driver for the combinational 32-bit ALU.
// Accepts one instruction, drives registered A/B/FUN for one EXEC cycle,
// captures the ALU result and offers it to writeback with its rd.
// Optional macro ALU_ISSUE_TRAP_EN: when defined, undecodable instructions
// travel through the pipeline and surface with ILLEGAL=1 and RESULT=0;
// when undefined they are accepted and silently dropped, ILLEGAL tied 0.
module alu_issue_unit
    import alu_issue_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [3:0]      dec_fun;
    logic            dec_illegal;

    state_t          state_q, state_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [3:0]      alu_fun_q, alu_fun_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            in_ready;
    logic            issue_ok;

    alu_issue_decode u_decode (
        .ir      (bus.ir),
        .pc      (bus.pc),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .a       (dec_a),
        .b       (dec_b),
        .fun     (dec_fun),
        .illegal (dec_illegal)
    );

    // Ready is masked by reset so upstream never sees a handshake during reset.
    assign in_ready      = rst_n && (state_q == IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fun   = alu_fun_q;
    assign bus.rd        = rd_q;
    assign bus.result    = result_q;

`ifdef ALU_ISSUE_TRAP_EN
    logic illegal_q, illegal_d;
    assign issue_ok    = 1'b1;
    assign bus.illegal = illegal_q;
`else
    assign issue_ok    = ~dec_illegal;
    assign bus.illegal = 1'b0;
`endif

    // Next-state and register-load logic; everything holds unless a transition loads it.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_fun_d = alu_fun_q;
        rd_d      = rd_q;
        result_d  = result_q;
`ifdef ALU_ISSUE_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready && issue_ok) begin
                    alu_a_d   = dec_a;
                    alu_b_d   = dec_b;
                    alu_fun_d = dec_fun;
                    rd_d      = bus.ir[11:7];
`ifdef ALU_ISSUE_TRAP_EN
                    illegal_d = dec_illegal;
`endif
                    state_d   = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_ISSUE_TRAP_EN
                result_d = illegal_q ? '0 : bus.alu_out;
`else
                result_d = bus.alu_out;
`endif
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= FUN_ADD;
            rd_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_fun_q <= alu_fun_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
        end
    end

`ifdef ALU_ISSUE_TRAP_EN
    // Illegal flag travels with the instruction it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed self-checking bench for alu_issue_unit.
// A behavioural ALU closes the loop; all expected values are hand-computed.
module tb_alu_issue_unit;
    import alu_issue_pkg::*;

    logic clk;
    logic rst_n = 1'b1;
    int   totalChecks = 0;
    int   passedChecks = 0;

    alu_issue_if bus_if ();

    alu_issue_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of the downstream combinational ALU.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] fun);
        case (fun)
            FUN_ADD:    return a + b;
            FUN_SUB:    return a - b;
            FUN_OR:     return a | b;
            FUN_AND:    return a & b;
            FUN_XOR:    return a ^ b;
            FUN_SRL:    return a >> b[4:0];
            FUN_SLL:    return a << b[4:0];
            FUN_SRA:    return $unsigned($signed(a) >>> b[4:0]);
            FUN_SLT:    return {31'b0, $signed(a) < $signed(b)};
            FUN_SLTU:   return {31'b0, a < b};
            FUN_PASS_A: return a;
            default:    return 32'h0;
        endcase
    endfunction

    // ALU sits outside the unit and answers combinationally.
    always_comb bus_if.alu_out = aluModel(bus_if.alu_a, bus_if.alu_b, bus_if.alu_fun);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got === exp) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ready, presents one instruction for exactly one accept edge.
    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
        int waited = 0;
        while (!bus_if.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) checkOutput("ready_timeout", {31'b0, bus_if.in_ready}, 32'h1);
        bus_if.ir       = ir;
        bus_if.pc       = pc;
        bus_if.rs1      = rs1;
        bus_if.rs2      = rs2;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Full issue/execute/writeback pass with checks in EXEC and DONE.
    task automatic runInstr(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] expA, input logic [31:0] expB,
                            input logic [3:0] expFun, input logic [31:0] expRes,
                            input logic [4:0] expRd, input logic expIll);
        applyStimulus(ir, pc, rs1, rs2);
        checkOutput({tag, "_a"}, bus_if.alu_a, expA);
        checkOutput({tag, "_b"}, bus_if.alu_b, expB);
        checkOutput({tag, "_fun"}, {28'b0, bus_if.alu_fun}, {28'b0, expFun});
        checkOutput({tag, "_exec_ready"}, {31'b0, bus_if.in_ready}, 32'h0);
        checkOutput({tag, "_exec_valid"}, {31'b0, bus_if.out_valid}, 32'h0);
        @(posedge clk); #1;
        checkOutput({tag, "_out_valid"}, {31'b0, bus_if.out_valid}, 32'h1);
        checkOutput({tag, "_result"}, bus_if.result, expRes);
        checkOutput({tag, "_rd"}, {27'b0, bus_if.rd}, {27'b0, expRd});
        checkOutput({tag, "_illegal"}, {31'b0, bus_if.illegal}, {31'b0, expIll});
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checkOutput({tag, "_drain_valid"}, {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput({tag, "_drain_ready"}, {31'b0, bus_if.in_ready}, 32'h1);
    endtask

    // Hard stop if something wedges the sequence below.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.ir        = '0;
        bus_if.pc        = '0;
        bus_if.rs1       = '0;
        bus_if.rs2       = '0;
        bus_if.out_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_in_ready", {31'b0, bus_if.in_ready}, 32'h0);
        checkOutput("rst_out_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("rst_alu_a", bus_if.alu_a, 32'h0);
        checkOutput("rst_alu_b", bus_if.alu_b, 32'h0);
        checkOutput("rst_alu_fun", {28'b0, bus_if.alu_fun}, 32'h0);
        checkOutput("rst_result", bus_if.result, 32'h0);
        checkOutput("rst_rd", {27'b0, bus_if.rd}, 32'h0);
        checkOutput("rst_illegal", {31'b0, bus_if.illegal}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", {31'b0, bus_if.in_ready}, 32'h1);

        // add x3,x1,x2
        runInstr("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, FUN_ADD, 32'd12, 5'd3, 1'b0);
        // srai x1,x1,3: B carries the whole sign-extended immediate 0x403, shamt 3 in B[4:0]
        runInstr("srai", 32'h4030D093, 32'h0, 32'h80000000, 32'h0, 32'h80000000, 32'h00000403,
                 FUN_SRA, 32'hF0000000, 5'd1, 1'b0);
        // addi x8,x1,-1: IR[30] set by the immediate must not turn into SUB
        runInstr("addi_neg", 32'hFFF08413, 32'h0, 32'd10, 32'h0, 32'd10, 32'hFFFFFFFF,
                 FUN_ADD, 32'd9, 5'd8, 1'b0);
        // lui x5,0x12345
        runInstr("lui", 32'h123452B7, 32'h0, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h0,
                 FUN_PASS_A, 32'h12345000, 5'd5, 1'b0);
        // auipc x6,0x1 at pc 0x100
        runInstr("auipc", 32'h00001317, 32'h100, 32'h0, 32'h0, 32'h100, 32'h1000,
                 FUN_ADD, 32'h1100, 5'd6, 1'b0);

        // Backpressure: sub x4,x1,x2 held in DONE while a new request is offered
        applyStimulus(32'h40208233, 32'h0, 32'd20, 32'd7);
        checkOutput("sub_fun", {28'b0, bus_if.alu_fun}, {28'b0, FUN_SUB});
        @(posedge clk); #1;
        bus_if.ir       = 32'h0020C4B3;
        bus_if.rs1      = 32'h11111111;
        bus_if.rs2      = 32'h22222222;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", {31'b0, bus_if.out_valid}, 32'h1);
            checkOutput("bp_result", bus_if.result, 32'd13);
            checkOutput("bp_rd", {27'b0, bus_if.rd}, 32'd4);
            checkOutput("bp_in_ready", {31'b0, bus_if.in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        checkOutput("bp_alu_a_hold", bus_if.alu_a, 32'd20);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checkOutput("bp_release_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("bp_release_ready", {31'b0, bus_if.in_ready}, 32'h1);

        // xor x9,x1,x2
        runInstr("xor", 32'h0020C4B3, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hF0F0F0F0,
                 32'h0FF00FF0, FUN_XOR, 32'hFF00FF00, 5'd9, 1'b0);

`ifdef ALU_ISSUE_TRAP_EN
        // Illegal opcode and illegal funct7 both surface with ILLEGAL and a zero result
        runInstr("ill_opc", 32'h0000007F, 32'h0, 32'h55, 32'h66, 32'h0, 32'h0, FUN_ADD,
                 32'h0, 5'd0, 1'b1);
        runInstr("ill_f7", 32'h02208233, 32'h0, 32'h55, 32'h66, 32'h0, 32'h0, FUN_ADD,
                 32'h0, 5'd4, 1'b1);
`else
        // Illegal instructions are swallowed in IDLE; operands keep the xor values
        applyStimulus(32'h0000007F, 32'h0, 32'h55, 32'h66);
        checkOutput("ill_opc_ready", {31'b0, bus_if.in_ready}, 32'h1);
        checkOutput("ill_opc_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("ill_opc_a_hold", bus_if.alu_a, 32'hF0F0F0F0);
        applyStimulus(32'h02208233, 32'h0, 32'h55, 32'h66);
        checkOutput("ill_f7_ready", {31'b0, bus_if.in_ready}, 32'h1);
        @(posedge clk); #1;
        checkOutput("ill_f7_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("ill_illegal_tied", {31'b0, bus_if.illegal}, 32'h0);
`endif

        // Reset asserted mid-EXEC discards the instruction
        applyStimulus(32'h002081B3, 32'h0, 32'd9, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'b0, bus_if.in_ready}, 32'h0);
        checkOutput("mid_rst_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("mid_rst_alu_a", bus_if.alu_a, 32'h0);
        checkOutput("mid_rst_alu_b", bus_if.alu_b, 32'h0);
        checkOutput("mid_rst_fun", {28'b0, bus_if.alu_fun}, 32'h0);
        checkOutput("mid_rst_result", bus_if.result, 32'h0);
        checkOutput("mid_rst_rd", {27'b0, bus_if.rd}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_valid", {31'b0, bus_if.out_valid}, 32'h0);
        checkOutput("post_rst_ready", {31'b0, bus_if.in_ready}, 32'h1);
        @(posedge clk); #1;
        checkOutput("post_rst_valid2", {31'b0, bus_if.out_valid}, 32'h0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
